// File: rtl/blockmem2p_rdstream.sv
// blockmem2p_rdstream: port-B read engine that turns (addr, len) commands into a valid/ready word stream with tlast.
// Latency: first enb one cycle after command acceptance; first m_tvalid G_RDLATENCY+1 cycles after the first enb.
// Backpressure: a read is issued only while FIFO entries plus in-flight reads stay below G_FIFODEPTH, so m_tready low never drops a word.
//
// Ports: clkb/resetn (async active-low); cmd_valid/cmd_ready/cmd_addr/cmd_len command in;
//        enb/addrb/doutb to the memory read port; m_tvalid/m_tready/m_tdata/m_tlast stream out;
//        busy (not IDLE), done (one-cycle pulse at command completion).
// Optional: define BLOCKMEM2P_RDSTREAM_ABORT_EN to add the abort input (flushes and ends the active command).
module blockmem2p_rdstream #(
  parameter int G_MEMWIDTH   = 32,
  parameter int G_MEMDEPTH   = 1024,
  parameter int G_RDLATENCY  = 1,
  parameter int G_FIFODEPTH  = 4,
  localparam int G_ADDRWIDTH = $clog2(G_MEMDEPTH)
) (
  input  logic                   clkb,
  input  logic                   resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [G_ADDRWIDTH-1:0] cmd_addr,
  input  logic [G_ADDRWIDTH:0]   cmd_len,
  output logic                   enb,
  output logic [G_ADDRWIDTH-1:0] addrb,
  input  logic [G_MEMWIDTH-1:0]  doutb,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [G_MEMWIDTH-1:0]  m_tdata,
  output logic                   m_tlast,
  output logic                   busy,
`ifdef BLOCKMEM2P_RDSTREAM_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   done
);

  localparam int LW = G_ADDRWIDTH + 1;
  localparam int PW = (G_FIFODEPTH > 1) ? $clog2(G_FIFODEPTH) : 1;
  localparam int CW = $clog2(G_FIFODEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     enb_q, enb_d;
  logic                     done_q, done_d;
  logic [G_ADDRWIDTH-1:0]   addrb_q, addrb_d;
  logic [LW-1:0]            rem_q, rem_d;      // reads still to issue
  logic [LW-1:0]            beats_q, beats_d;  // beats still to deliver
  logic [G_RDLATENCY-1:0]   vld_q, vld_d;      // tracks reads travelling through the memory pipeline
  logic [G_MEMWIDTH-1:0]    mem_q [G_FIFODEPTH];
  logic [G_MEMWIDTH-1:0]    mem_d [G_FIFODEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d, infl_q, infl_d;

  logic                     push, pop, last_hs, credit_ok, abort_hit;
  logic [LW-1:0]            len_sat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(G_FIFODEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [G_ADDRWIDTH-1:0] addr_inc(input logic [G_ADDRWIDTH-1:0] a);
    return (a == G_ADDRWIDTH'(G_MEMDEPTH - 1)) ? '0 : a + G_ADDRWIDTH'(1);
  endfunction

`ifdef BLOCKMEM2P_RDSTREAM_ABORT_EN
  assign abort_hit = abort && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign push      = vld_q[G_RDLATENCY-1];
  assign pop       = m_tvalid && m_tready;
  assign last_hs   = pop && (beats_q == LW'(1));
  // FIFO entries plus reads already issued must never exceed the FIFO size.
  assign credit_ok = ({1'b0, cnt_q} + {1'b0, infl_q}) < (CW + 1)'(G_FIFODEPTH);
  assign len_sat   = (cmd_len > LW'(G_MEMDEPTH)) ? LW'(G_MEMDEPTH) : cmd_len;

  always_comb begin
    state_d  = state_q;
    enb_d    = 1'b0;
    addrb_d  = addrb_q;
    rem_d    = rem_q;
    beats_d  = beats_q;
    done_d   = 1'b0;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = '0;
    vld_d[0] = enb_q;
    for (int i = 1; i < G_RDLATENCY; i++) vld_d[i] = vld_q[i-1];

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      beats_d  = beats_q - LW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = doutb;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (len_sat == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            enb_d   = 1'b1;
            addrb_d = cmd_addr;
            rem_d   = len_sat - LW'(1);
            beats_d = len_sat;
          end
        end
      end
      S_ISSUE: begin
        if ((rem_q != '0) && credit_ok) begin
          enb_d   = 1'b1;
          addrb_d = addr_inc(addrb_q);
          rem_d   = rem_q - LW'(1);
        end
        if ((rem_q == '0) || (enb_d && (rem_q == LW'(1)))) state_d = S_DRAIN;
      end
      S_DRAIN: ;
      default: state_d = S_IDLE;
    endcase

    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    infl_d = infl_q + CW'(enb_d) - CW'(push);

    if (last_hs) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end

    // Abort drops everything queued or still in the memory pipeline.
    if (abort_hit) begin
      state_d  = S_IDLE;
      enb_d    = 1'b0;
      done_d   = 1'b1;
      rem_d    = '0;
      beats_d  = '0;
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      infl_d   = '0;
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clkb or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      enb_q       <= 1'b0;
      done_q      <= 1'b0;
      addrb_q     <= '0;
      rem_q       <= '0;
      beats_q     <= '0;
      vld_q       <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      infl_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      enb_q       <= enb_d;
      done_q      <= done_d;
      addrb_q     <= addrb_d;
      rem_q       <= rem_d;
      beats_q     <= beats_d;
      vld_q       <= vld_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      infl_q      <= infl_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign enb       = enb_q;
  assign addrb     = addrb_q;
  assign m_tvalid  = (cnt_q != '0);
  assign m_tdata   = mem_q[rd_ptr_q];
  assign m_tlast   = m_tvalid && (beats_q == LW'(1));
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_blockmem2p_rdstream.sv
// Testbench for blockmem2p_rdstream at default parameters, with a one-cycle-latency memory holding word i = 0xA5000000+i.
// Latency: expects first enb in the cycle after acceptance and first m_tvalid two cycles later.
// Backpressure: m_tready is held low, randomised or held high per command.
module tb_blockmem2p_rdstream;
  localparam int W  = 32;
  localparam int D  = 1024;
  localparam int AW = 10;
  localparam int FD = 4;

  logic          clkb = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          m_tready = 1'b0;
  logic          cmd_ready, enb, m_tvalid, m_tlast, busy, done;
  logic [AW-1:0] addrb;
  logic [W-1:0]  doutb, m_tdata;
`ifdef BLOCKMEM2P_RDSTREAM_ABORT_EN
  logic          abort = 1'b0;
`endif

  logic [W-1:0]  mem [D];
  int            n_tot = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            acc_cyc = 0;

  // written only by the monitor
  logic [W-1:0]  rx_dat[$];
  bit            rx_last[$];
  int            rx_cyc[$];
  int            enb_cyc[$];
  logic [AW-1:0] enb_addr[$];
  int            vld_cyc[$];
  int            done_cnt = 0;
  int            done_cyc = -1;
  logic          hold_pend = 1'b0;
  logic [W-1:0]  hold_dat = '0;
  logic          hold_last = 1'b0;

  blockmem2p_rdstream dut (
    .clkb      (clkb),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .enb       (enb),
    .addrb     (addrb),
    .doutb     (doutb),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .busy      (busy),
`ifdef BLOCKMEM2P_RDSTREAM_ABORT_EN
    .abort     (abort),
`endif
    .done      (done)
  );

  initial forever #5 clkb = ~clkb;

  always @(posedge clkb) cyc <= cyc + 1;

  always @(posedge clkb) if (enb) doutb <= mem[addrb];

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clkb) begin
    if (resetn) begin
      if (enb) begin
        enb_cyc.push_back(cyc);
        enb_addr.push_back(addrb);
        chk_val("enb_busy", busy, 1);
      end
      if (m_tvalid) vld_cyc.push_back(cyc);
      if (hold_pend) begin
        chk_val("hold_vld", m_tvalid, 1);
        chk_val("hold_dat", m_tdata, hold_dat);
        chk_val("hold_last", m_tlast, hold_last);
      end
      hold_pend <= m_tvalid && !m_tready;
      hold_dat  <= m_tdata;
      hold_last <= m_tlast;
      if (m_tvalid && m_tready) begin
        rx_dat.push_back(m_tdata);
        rx_last.push_back(m_tlast);
        rx_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
        chk_val("done_rdy", cmd_ready, 1);
        chk_val("done_busy", busy, 0);
      end
    end else begin
      hold_pend <= 1'b0;
    end
  end

  function automatic logic [W-1:0] exp_word(input int a, input int k);
    return 32'hA500_0000 + W'((a + k) % D);
  endfunction

  task automatic send_cmd(input int a, input int l);
    int n = 0;
    cmd_addr  = AW'(a);
    cmd_len   = (AW+1)'(l);
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(posedge clkb); #1;
      n++;
    end
    chk_val("cmd_rdy", cmd_ready, 1);
    @(posedge clkb); #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input bit rnd);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      if (rnd) m_tready = ($urandom_range(0, 3) != 0);
      @(posedge clkb); #1;
      n++;
    end
    m_tready = 1'b1;
    repeat (3) begin @(posedge clkb); #1; end
  endtask

  task automatic run_cmd(input int a, input int l, input bit rnd, input int stall,
                         output int eb, output int rb);
    int n, vb, db, got, k;
    n  = (l > D) ? D : l;
    eb = enb_cyc.size();
    rb = rx_dat.size();
    vb = vld_cyc.size();
    db = done_cnt;
    if (stall > 0) m_tready = 1'b0;
    else if (!rnd) m_tready = 1'b1;
    send_cmd(a, l);
    if (stall > 0) begin
      k = 0;
      while (!m_tvalid && k < 20) begin @(posedge clkb); #1; k++; end
      repeat (stall) begin @(posedge clkb); #1; end
      chk_val("stall_enb_le_depth", (enb_cyc.size() - eb) <= FD, 1);
      chk_val("stall_beats", rx_dat.size() - rb, 0);
      m_tready = 1'b1;
    end
    wait_done(db + 1, 8 * n + 60, rnd);
    got = rx_dat.size() - rb;
    chk_val("done_cnt", done_cnt - db, 1);
    chk_val("nbeats", got, n);
    chk_val("nenb", enb_cyc.size() - eb, n);
    for (int i = 0; i < n && i < got; i++) begin
      chk_val($sformatf("dat%0d", i), rx_dat[rb+i], exp_word(a, i));
      chk_val($sformatf("last%0d", i), rx_last[rb+i], (i == n - 1));
    end
    if (n == 0) begin
      chk_val("len0_vld", vld_cyc.size() - vb, 0);
      chk_val("len0_done_lat", done_cyc - acc_cyc, 0);
      chk_val("len0_rdy", cmd_ready, 1);
    end else if (got == n && enb_cyc.size() > eb && vld_cyc.size() > vb) begin
      chk_val("enb_lat", enb_cyc[eb] - acc_cyc, 0);
      chk_val("vld_lat", vld_cyc[vb] - enb_cyc[eb], 2);
      chk_val("done_lat", done_cyc - rx_cyc[rb+n-1], 1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_val({tag, "_cmd_ready"}, cmd_ready, 0);
    chk_val({tag, "_enb"}, enb, 0);
    chk_val({tag, "_addrb"}, addrb, 0);
    chk_val({tag, "_tvalid"}, m_tvalid, 0);
    chk_val({tag, "_tdata"}, m_tdata, 0);
    chk_val({tag, "_tlast"}, m_tlast, 0);
    chk_val({tag, "_busy"}, busy, 0);
    chk_val({tag, "_done"}, done, 0);
  endtask

  initial begin
    int eb, rb, n, a, l, db;
    for (int i = 0; i < D; i++) mem[i] = 32'hA500_0000 + W'(i);

    #3;
    chk_reset_outputs("rst0");
    @(posedge clkb); #1;
    resetn = 1'b1;
    @(posedge clkb); #1;
    chk_val("rdy_after_rst", cmd_ready, 1);

    // single word
    run_cmd(32'h005, 1, 1'b0, 0, eb, rb);

    // address wrap, gapless stream
    run_cmd(32'h3FE, 4, 1'b0, 0, eb, rb);
    if (enb_addr.size() >= eb + 4 && rx_cyc.size() >= rb + 4) begin
      chk_val("wrap_a0", enb_addr[eb],   10'h3FE);
      chk_val("wrap_a1", enb_addr[eb+1], 10'h3FF);
      chk_val("wrap_a2", enb_addr[eb+2], 10'h000);
      chk_val("wrap_a3", enb_addr[eb+3], 10'h001);
      chk_val("wrap_enb_gapless", enb_cyc[eb+3] - enb_cyc[eb], 3);
      chk_val("wrap_beat_gapless", rx_cyc[rb+3] - rx_cyc[rb], 3);
    end else begin
      chk_val("wrap_seen", 0, 1);
    end

    // backpressure for 10 cycles after the first beat appears
    run_cmd(32'h010, 16, 1'b0, 10, eb, rb);

    // zero-length command
    run_cmd(32'h123, 0, 1'b0, 0, eb, rb);

    // length beyond the memory saturates to a full sweep
    run_cmd(32'h200, 1100, 1'b1, 0, eb, rb);

    // reset in the middle of a transfer
    m_tready = 1'b1;
    rb = rx_dat.size();
    send_cmd(32'h040, 8);
    n = 0;
    while (rx_dat.size() - rb < 3 && n < 50) begin @(negedge clkb); #1; n++; end
    chk_val("rst_mid_progress", rx_dat.size() - rb, 3);
    @(posedge clkb);
    #2 resetn = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    repeat (2) @(posedge clkb);
    #1 resetn = 1'b1;
    @(posedge clkb); #1;
    run_cmd(32'h000, 2, 1'b0, 0, eb, rb);

`ifdef BLOCKMEM2P_RDSTREAM_ABORT_EN
    // abort in IDLE has no effect
    db = done_cnt;
    abort = 1'b1;
    @(posedge clkb); #1;
    abort = 1'b0;
    repeat (2) begin @(posedge clkb); #1; end
    chk_val("abort_idle_done", done_cnt - db, 0);

    // abort after two beats of eight
    m_tready = 1'b1;
    rb = rx_dat.size();
    db = done_cnt;
    send_cmd(32'h080, 8);
    n = 0;
    while (rx_dat.size() - rb < 2 && n < 50) begin @(negedge clkb); #1; n++; end
    abort = 1'b1;
    @(posedge clkb); #1;
    abort = 1'b0;
    chk_val("abort_tvalid", m_tvalid, 0);
    chk_val("abort_enb", enb, 0);
    chk_val("abort_done", done, 1);
    chk_val("abort_rdy", cmd_ready, 1);
    repeat (6) begin @(posedge clkb); #1; end
    chk_val("abort_beats", rx_dat.size() - rb, 2);
    chk_val("abort_done_cnt", done_cnt - db, 1);
    chk_val("abort_busy", busy, 0);
    run_cmd(32'h100, 3, 1'b0, 0, eb, rb);
`endif

    // randomised commands and backpressure
    for (int t = 0; t < 14; t++) begin
      a = int'($urandom_range(0, D - 1));
      l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
      run_cmd(a, l, 1'b1, 0, eb, rb);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
